// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit engine.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int DATA_WIDTH_MIN = 5;
  localparam int DATA_WIDTH_MAX = 9;
  localparam int STOP_BITS_MIN  = 1;
  localparam int STOP_BITS_MAX  = 2;

endpackage

// File: rtl/uart_tx_engine_parity.sv
// Parity bit generator: XOR reduce of the payload, inverted for odd parity.
module uart_parity_gen
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_par_typ,
  output logic                  o_parity
);

  logic w_xor;

  assign w_xor    = ^i_data;
  assign o_parity = (i_par_typ == PAR_ODD) ? ~w_xor : w_xor;

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: start, LSB-first data, optional parity, 1-2 stop bits, back-to-back frames.
// Optional line-break generation is compiled in with UART_TX_BREAK_EN.
module uart_tx_engine
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
`ifdef UART_TX_BREAK_EN
  input  logic                  break_req,
`endif
  output logic                  ready,
  output logic                  busy,
  output logic                  TX_OUT
);

  localparam int                 CW        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0]      CNT_LAST  = CW'(DATA_WIDTH - 1);
  localparam logic               STOP_LAST = 1'(STOP_BITS - 1);

  tx_state_e             r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic                  r_stop, w_stop_nxt;
  logic                  r_par, w_par_nxt;
  logic                  r_par_en, w_par_en_nxt;
  logic                  r_tx, w_tx_nxt;
  logic                  w_ready, w_busy, w_load, w_parity;
`ifdef UART_TX_BREAK_EN
  logic                  r_mark, w_mark_nxt;
`endif

  uart_parity_gen #(.DATA_WIDTH(DATA_WIDTH)) u_par (
    .i_data    (P_DATA),
    .i_par_typ (PAR_TYP),
    .o_parity  (w_parity)
  );

  // TX_OUT is registered, so the comb block computes the line level for the next cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_cnt_nxt    = r_cnt;
    w_stop_nxt   = r_stop;
    w_par_nxt    = r_par;
    w_par_en_nxt = r_par_en;
    w_tx_nxt     = r_tx;
    w_ready      = 1'b0;
    w_busy       = 1'b1;
    w_load       = 1'b0;
`ifdef UART_TX_BREAK_EN
    w_mark_nxt   = r_mark;
`endif
    case (r_state)
      ST_IDLE: begin
        w_busy   = 1'b0;
        w_tx_nxt = 1'b1;
`ifdef UART_TX_BREAK_EN
        if (break_req) begin
          w_state_nxt = ST_BREAK;
          w_tx_nxt    = 1'b0;
        end else
`endif
        begin
          w_ready = 1'b1;
          w_load  = Data_Valid;
        end
      end
      ST_START: begin
        w_state_nxt = ST_DATA;
        w_cnt_nxt   = '0;
        w_tx_nxt    = r_shift[0];
        w_shift_nxt = r_shift >> 1;
      end
      ST_DATA: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt = '0;
          if (r_par_en) begin
            w_state_nxt = ST_PARITY;
            w_tx_nxt    = r_par;
          end else begin
            w_state_nxt = ST_STOP;
            w_tx_nxt    = 1'b1;
            w_stop_nxt  = 1'b0;
          end
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
          w_tx_nxt    = r_shift[0];
          w_shift_nxt = r_shift >> 1;
        end
      end
      ST_PARITY: begin
        w_state_nxt = ST_STOP;
        w_tx_nxt    = 1'b1;
        w_stop_nxt  = 1'b0;
      end
      ST_STOP: begin
        w_tx_nxt = 1'b1;
        if (r_stop == STOP_LAST) begin
          w_ready     = 1'b1;
          w_load      = Data_Valid;
          w_state_nxt = ST_IDLE;
        end else begin
          w_stop_nxt = r_stop + 1'b1;
        end
      end
`ifdef UART_TX_BREAK_EN
      ST_BREAK: begin
        if (r_mark) begin
          w_state_nxt = ST_IDLE;
          w_mark_nxt  = 1'b0;
          w_tx_nxt    = 1'b1;
        end else if (!break_req) begin
          w_mark_nxt = 1'b1;
          w_tx_nxt   = 1'b1;
        end else begin
          w_tx_nxt = 1'b0;
        end
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
        w_tx_nxt    = 1'b1;
        w_busy      = 1'b0;
      end
    endcase

    // Acceptance (IDLE or last stop bit) snapshots everything the frame depends on.
    if (w_load) begin
      w_state_nxt  = ST_START;
      w_tx_nxt     = 1'b0;
      w_shift_nxt  = P_DATA;
      w_par_en_nxt = PAR_EN;
      w_par_nxt    = w_parity;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state  <= ST_IDLE;
      r_shift  <= '0;
      r_cnt    <= '0;
      r_stop   <= 1'b0;
      r_par    <= 1'b0;
      r_par_en <= 1'b0;
      r_tx     <= 1'b1;
`ifdef UART_TX_BREAK_EN
      r_mark   <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_shift  <= w_shift_nxt;
      r_cnt    <= w_cnt_nxt;
      r_stop   <= w_stop_nxt;
      r_par    <= w_par_nxt;
      r_par_en <= w_par_en_nxt;
      r_tx     <= w_tx_nxt;
`ifdef UART_TX_BREAK_EN
      r_mark   <= w_mark_nxt;
`endif
    end
  end

  assign ready  = w_ready;
  assign busy   = w_busy;
  assign TX_OUT = r_tx;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench for uart_tx_engine: three instances (8b/1stop, 8b/2stop, 5b/1stop) share inputs.
module tb_uart_tx_engine;

  typedef struct packed {logic tx; logic busy; logic rdy;} smp_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       Data_Valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [7:0] P_DATA8 = 8'h00;
  logic [4:0] P_DATA5;
`ifdef UART_TX_BREAK_EN
  logic       break_req = 1'b0;
`endif
  logic tx_a, busy_a, rdy_a;
  logic tx_b, busy_b, rdy_b;
  logic tx_c, busy_c, rdy_c;

  smp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  assign P_DATA5 = P_DATA8[4:0];
  always #5 CLK = ~CLK;

  uart_tx_engine #(.DATA_WIDTH(8), .STOP_BITS(1)) u_a (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA8), .Data_Valid(Data_Valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
`ifdef UART_TX_BREAK_EN
    .break_req(break_req),
`endif
    .ready(rdy_a), .busy(busy_a), .TX_OUT(tx_a));

  uart_tx_engine #(.DATA_WIDTH(8), .STOP_BITS(2)) u_b (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA8), .Data_Valid(Data_Valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
`ifdef UART_TX_BREAK_EN
    .break_req(break_req),
`endif
    .ready(rdy_b), .busy(busy_b), .TX_OUT(tx_b));

  uart_tx_engine #(.DATA_WIDTH(5), .STOP_BITS(1)) u_c (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA5), .Data_Valid(Data_Valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
`ifdef UART_TX_BREAK_EN
    .break_req(break_req),
`endif
    .ready(rdy_c), .busy(busy_c), .TX_OUT(tx_c));

  function automatic smp_t obs(input int sel);
    case (sel)
      0:       return {tx_a, busy_a, rdy_a};
      1:       return {tx_b, busy_b, rdy_b};
      default: return {tx_c, busy_c, rdy_c};
    endcase
  endfunction

  // Reference frame: start, LSB-first data, optional parity, stop bits (ready only on the last).
  task automatic push_frame(input logic [7:0] d, input int w, input logic pe, input logic pt,
                            input int sbits);
    logic p;
    p = pt;
    sb.push_back(3'b010);
    for (int i = 0; i < w; i++) begin
      p = p ^ d[i];
      sb.push_back({d[i], 1'b1, 1'b0});
    end
    if (pe) sb.push_back({p, 1'b1, 1'b0});
    for (int i = 0; i < sbits; i++) sb.push_back({1'b1, 1'b1, (i == sbits - 1)});
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) sb.push_back(3'b101);
  endtask

  task automatic settle();
    repeat (16) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    smp_t o;
    #1 RST = 1'b0;
    #2;
    for (int s = 0; s < 3; s++) begin
      o = obs(s); n_vec++;
      if (o !== 3'b101) begin
        n_err++;
        $display("FAIL reset_state dut%0d: got tx/busy/rdy=%b expected 101", s, o);
      end
    end
    @(negedge CLK) RST = 1'b1;
    @(posedge CLK); #1;
    o = obs(0); n_vec++;
    if (o !== 3'b101) begin
      n_err++;
      $display("FAIL reset_release: got tx/busy/rdy=%b expected 101", o);
    end
  endtask

  task automatic test_basic();
    smp_t e, o;
    PAR_EN = 1'b0; P_DATA8 = 8'hA5; Data_Valid = 1'b1;
    push_frame(8'hA5, 8, 1'b0, 1'b0, 1); push_idle(2);
    for (int k = 0; sb.size() > 0; k++) begin
      @(posedge CLK); #1;
      if (k == 0) Data_Valid = 1'b0;
      e = sb.pop_front(); o = obs(0); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL basic_a5 cyc%0d: got tx/busy/rdy=%b expected %b", k, o, e);
      end
    end
    settle();
  endtask

  task automatic test_parity();
    smp_t e, o;
    for (int t = 0; t < 2; t++) begin
      PAR_EN = 1'b1; PAR_TYP = (t == 1); P_DATA8 = 8'h07; Data_Valid = 1'b1;
      push_frame(8'h07, 8, 1'b1, (t == 1), 1); push_idle(2);
      for (int k = 0; sb.size() > 0; k++) begin
        @(posedge CLK); #1;
        if (k == 0) Data_Valid = 1'b0;
        e = sb.pop_front(); o = obs(0); n_vec++;
        if (o !== e) begin
          n_err++;
          $display("FAIL parity_typ%0d cyc%0d: got tx/busy/rdy=%b expected %b", t, k, o, e);
        end
      end
      settle();
    end
    PAR_EN = 1'b0; PAR_TYP = 1'b0;
  endtask

  task automatic test_back_to_back();
    smp_t e, o;
    P_DATA8 = 8'h55; Data_Valid = 1'b1;
    push_frame(8'h55, 8, 1'b0, 1'b0, 2);
    push_frame(8'hAA, 8, 1'b0, 1'b0, 2);
    push_idle(2);
    for (int k = 0; sb.size() > 0; k++) begin
      @(posedge CLK); #1;
      if (k == 0) P_DATA8 = 8'hAA;
      if (k == 11) Data_Valid = 1'b0;
      e = sb.pop_front(); o = obs(1); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL back_to_back cyc%0d: got tx/busy/rdy=%b expected %b", k, o, e);
      end
    end
    settle();
  endtask

  task automatic test_width5();
    smp_t e, o;
    PAR_EN = 1'b0; PAR_TYP = 1'b0; P_DATA8 = 8'h1F; Data_Valid = 1'b1;
    push_frame(8'h1F, 5, 1'b0, 1'b0, 1); push_idle(2);
    for (int k = 0; sb.size() > 0; k++) begin
      @(posedge CLK); #1;
      if (k == 0) Data_Valid = 1'b0;
      if (k == 2) begin PAR_EN = 1'b1; PAR_TYP = 1'b1; P_DATA8 = 8'h00; end
      e = sb.pop_front(); o = obs(2); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL width5_midchange cyc%0d: got tx/busy/rdy=%b expected %b", k, o, e);
      end
    end
    PAR_EN = 1'b0; PAR_TYP = 1'b0;
    settle();
  endtask

  task automatic test_reset_mid();
    smp_t e, o;
    P_DATA8 = 8'hA5; Data_Valid = 1'b1;
    push_frame(8'hA5, 8, 1'b0, 1'b0, 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge CLK); #1;
      if (k == 0) Data_Valid = 1'b0;
      e = sb.pop_front(); o = obs(0); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL reset_mid_pre cyc%0d: got tx/busy/rdy=%b expected %b", k, o, e);
      end
    end
    sb.delete();
    RST = 1'b0;
    #1;
    o = obs(0); n_vec++;
    if (o !== 3'b101) begin
      n_err++;
      $display("FAIL reset_mid_abort: got tx/busy/rdy=%b expected 101", o);
    end
    @(negedge CLK) RST = 1'b1;
    @(posedge CLK); #1;
    P_DATA8 = 8'h3C; Data_Valid = 1'b1;
    push_frame(8'h3C, 8, 1'b0, 1'b0, 1); push_idle(2);
    for (int k = 0; sb.size() > 0; k++) begin
      @(posedge CLK); #1;
      if (k == 0) Data_Valid = 1'b0;
      e = sb.pop_front(); o = obs(0); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL reset_mid_refill cyc%0d: got tx/busy/rdy=%b expected %b", k, o, e);
      end
    end
    settle();
  endtask

`ifdef UART_TX_BREAK_EN
  task automatic test_break();
    smp_t e, o;
    P_DATA8 = 8'h5A; Data_Valid = 1'b1; break_req = 1'b1;
    for (int i = 0; i < 3; i++) sb.push_back(3'b010);
    sb.push_back(3'b110);
    sb.push_back(3'b101);
    push_frame(8'h5A, 8, 1'b0, 1'b0, 1); push_idle(2);
    for (int k = 0; sb.size() > 0; k++) begin
      @(posedge CLK); #1;
      if (k == 2) break_req = 1'b0;
      if (k == 5) Data_Valid = 1'b0;
      e = sb.pop_front(); o = obs(0); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL break cyc%0d: got tx/busy/rdy=%b expected %b", k, o, e);
      end
    end
    settle();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_width5();
    test_reset_mid();
`ifdef UART_TX_BREAK_EN
    test_break();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
